serial_adder_ctrl: RTL and testbench

- Bit-serial WIDTH-bit adder built around one ful_use_nand cell (ports a, b, c, sum, carry) that acts as the bit slice.
- The block feeds the cell one operand bit pair per clock, registers the cell's carry back into its c input, and collects sum bits into a result shift register.
- It sits downstream of operand sources. It gives a start/busy/done handshake so a multi-bit add reuses the single NAND full adder.

---
 rtl/serial_adder_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. A single NAND-only full-adder cell
// processes one operand bit pair per clock; the carry is registered back into
// the cell and sum bits are collected LSB-first into a shift register.

// NAND-only full adder used as the bit slice.
module ful_use_nand (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   logic n1, n2, n3, x1, n4, n5, n6;

   assign n1    = ~(a & b);
   assign n2    = ~(a & n1);
   assign n3    = ~(b & n1);
   assign x1    = ~(n2 & n3);   // a ^ b
   assign n4    = ~(x1 & c);
   assign n5    = ~(x1 & n4);
   assign n6    = ~(c & n4);
   assign sum   = ~(n5 & n6);   // a ^ b ^ c
   assign carry = ~(n4 & n1);   // (a & b) | (c & (a ^ b))

endmodule

// Start/busy/done sequencer wrapped around the serial bit slice.
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             cell_sum;
   logic             cell_carry;
   logic [WIDTH-1:0] s_shift;

   ful_use_nand u_slice (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c     (carry_q),
      .sum   (cell_sum),
      .carry (cell_carry)
   );

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign sum_out = sum_q;
   assign cout    = cout_q;

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      // Built by shift-then-overwrite so WIDTH=1 needs no zero-width slice.
      s_shift            = s_sr_q >> 1;
      s_shift[WIDTH-1]   = cell_sum;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a_in;
               b_sr_d  = b_in;
               carry_d = cin;
               s_sr_d  = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_sr_d  = s_shift;
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = cell_carry;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Result registers take the values produced by this final edge.
               sum_d   = s_shift;
               cout_d  = cell_carry;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 main instance plus a
// WIDTH=1 instance for the full-adder truth table.
module tb_serial_adder_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a_in, b_in;
   logic       cin;
   logic       busy, done, cout;
   logic [7:0] sum_out;

   logic       start1, a1, b1, cin1;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;
   logic [0:0] a1v, b1v;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done = 0;
   bit have_prev = 0;
   bit period_chk = 0;

   logic [8:0] sb[$];
   logic [1:0] sb1[$];

   assign a1v = a1;
   assign b1v = b1;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .cin(cin), .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
   );

   serial_adder_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1v), .b_in(b1v),
      .cin(cin1), .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor for the 8-bit instance: pop an expectation on every done pulse.
   always @(negedge clk) begin
      if (!period_chk) have_prev = 0;
      if (done === 1'b1) begin
         done_cnt++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done got=%h_%h expected no done", cout, sum_out);
         end else begin
            logic [8:0] e;
            e = sb.pop_front();
            if ({cout, sum_out} !== e) begin
               errors++;
               $display("FAIL result got cout=%b sum=%h expected cout=%b sum=%h",
                        cout, sum_out, e[8], e[7:0]);
            end
         end
         if (period_chk && have_prev) begin
            checks++;
            if (cyc - last_done != 10) begin
               errors++;
               $display("FAIL done_period got=%0d expected=10", cyc - last_done);
            end
         end
         last_done = cyc;
         have_prev = 1;
      end
   end

   // Monitor for the 1-bit instance.
   always @(negedge clk) begin
      if (done1 === 1'b1) begin
         checks++;
         if (sb1.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done1 got=%b%b expected no done", cout1, sum1);
         end else begin
            logic [1:0] e;
            e = sb1.pop_front();
            if ({cout1, sum1} !== e) begin
               errors++;
               $display("FAIL fa1 got cout=%b sum=%b expected cout=%b sum=%b",
                        cout1, sum1, e[1], e[0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   // Present operands with start for one accepting edge; optionally record the expectation.
   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp, input bit push);
      @(negedge clk);
      a_in = a; b_in = b; cin = c; start = 1'b1;
      if (push) sb.push_back(exp);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || sb1.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0 || sb1.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout got pending=%0d expected pending=0", name, sb.size() + sb1.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [1:0] fa_tab [8];
      int d0;
      fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      rst_n = 0; start = 0; a_in = '0; b_in = '0; cin = 0;
      start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_cout", cout, 0);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // 0x5A+0x3C with cycle-accurate busy/done timing.
      launch(8'h5A, 8'h3C, 1'b0, 9'h096, 1);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk($sformatf("busy_c%0d", i), {busy, done}, 2'b10);
      end
      @(negedge clk);
      chk("done_pulse", {busy, done}, 2'b01);
      @(negedge clk);
      chk("done_single", {busy, done}, 2'b00);
      chk("sum_held", sum_out, 8'h96);
      drain("t1");

      launch(8'hFF, 8'h01, 1'b0, 9'h100, 1); drain("ff01");
      launch(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1); drain("ffff1");
      launch(8'h00, 8'h00, 1'b1, 9'h001, 1); drain("0001");

      // Start reasserted during RUN must be ignored.
      d0 = done_cnt;
      launch(8'h0F, 8'h01, 1'b0, 9'h010, 1);
      @(negedge clk); @(negedge clk);
      a_in = 8'h11; b_in = 8'h22; start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      drain("ignore");
      chk("ignore_one_done", done_cnt - d0, 1);

      // Operands change right after capture.
      launch(8'h03, 8'h04, 1'b0, 9'h007, 1);
      a_in = 8'hAA; b_in = 8'h55; cin = 1'b1;
      drain("opchg");

      // Reset mid-RUN aborts; no done from the aborted add.
      d0 = done_cnt;
      launch(8'h3C, 8'h5A, 1'b0, 9'h000, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_sum", sum_out, 0);
      chk("midrst_cout", cout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      launch(8'h80, 8'h80, 1'b0, 9'h100, 1); drain("8080");

      // start held for 30 cycles: three back-to-back adds, period 10.
      period_chk = 1;
      d0 = done_cnt;
      @(negedge clk);
      a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(9'h046);
      repeat (30) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      drain("held");
      chk("held_done_count", done_cnt - d0, 3);
      period_chk = 0;

      // WIDTH=1 instance against the full-adder truth table.
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv = 3'(v);
         @(negedge clk);
         a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; start1 = 1'b1;
         sb1.push_back(fa_tab[v]);
         @(posedge clk);
         #1 start1 = 1'b0;
         @(negedge clk);
         chk($sformatf("busy1_%0d", v), {busy1, done1}, 2'b10);
         drain($sformatf("fa1_%0d", v));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
